branch_predictor: RTL and testbench

//  IF-stage BTB + 2-bit BHT that generates predict_br / BHT_predict, which the ID and ID/EX seg regs carry down to EX.

---
 rtl/bp_pkg.sv | 31 +++
 rtl/bht_table.sv | 43 ++++
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// Package : bp_pkg
// Shared BHT counter encodings and the saturating-counter update function.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package bp_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_SNT   = 2'b00;
  localparam bht_ctr_t BHT_WNT   = 2'b01;
  localparam bht_ctr_t BHT_WT    = 2'b10;
  localparam bht_ctr_t BHT_ST    = 2'b11;
  localparam bht_ctr_t BHT_RESET = BHT_SNT + 2'b01;

  function automatic bht_ctr_t next_ctr(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != BHT_ST) res = ctr + 2'b01;
    end else begin
      if (ctr != BHT_SNT) res = ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bht_table.sv
// ---------------------------------------------------------------------------
// Module : bht_table
// Direct-mapped array of 2-bit saturating counters, one read and one update port.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bht_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int DEPTH = 1 << IDX_W;

  bht_ctr_t ctr_q [DEPTH];
  bht_ctr_t ctr_d;

  assign ctr_d    = next_ctr(ctr_q[upd_idx_i], upd_taken_i);
  // Read sees the array before this cycle's write lands.
  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_RESET;
      end
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// Module : branch_predictor
// IF-stage BTB + 2-bit BHT lookup, EX-stage resolve/update and perf counters.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module branch_predictor
  import bp_pkg::*;
#(
  parameter int BTB_IDX_W = 6,
  parameter int BHT_IDX_W = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC_IF,
  output logic             predict_br_IF,
  output logic             BHT_predict_IF,
  output logic [31:0]      predict_target_IF,
  input  logic             upd_en,
  input  logic             br_EX,
  input  logic             br_taken_EX,
  input  logic [31:0]      br_target_EX,
  input  logic [31:0]      PC_EX,
  input  logic             predict_br_EX,
  input  logic             BHT_predict_EX,
  input  logic [31:0]      pred_target_EX,
  output logic             mispredict_EX,
  output logic [31:0]      correct_pc_EX,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int BTB_DEPTH = 1 << BTB_IDX_W;
  localparam int TAG_W     = 32 - BTB_IDX_W - 2;

  logic             btb_valid_q [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag_q   [BTB_DEPTH];
  logic [31:0]      btb_tgt_q   [BTB_DEPTH];
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [BTB_IDX_W-1:0] w_if_btb_idx, w_ex_btb_idx;
  logic [TAG_W-1:0]     w_if_tag, w_ex_tag;
  logic                 w_btb_hit;
  logic [1:0]           w_if_ctr;
  logic                 w_upd;
  logic                 w_unused_bits;

  assign w_if_btb_idx = PC_IF[BTB_IDX_W+1:2];
  assign w_if_tag     = PC_IF[31:BTB_IDX_W+2];
  assign w_ex_btb_idx = PC_EX[BTB_IDX_W+1:2];
  assign w_ex_tag     = PC_EX[31:BTB_IDX_W+2];
  assign w_upd        = upd_en && br_EX;

  // The carried BHT bit is informational only; the resolve needs just the final prediction.
  assign w_unused_bits = ^{PC_IF[1:0], PC_EX[1:0], BHT_predict_EX};

  bht_table #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (PC_IF[BHT_IDX_W+1:2]),
    .rd_ctr_o   (w_if_ctr),
    .upd_en_i   (w_upd),
    .upd_idx_i  (PC_EX[BHT_IDX_W+1:2]),
    .upd_taken_i(br_taken_EX)
  );

  assign w_btb_hit         = btb_valid_q[w_if_btb_idx] && (btb_tag_q[w_if_btb_idx] == w_if_tag);
  assign BHT_predict_IF    = w_if_ctr[1];
  assign predict_br_IF     = w_btb_hit && w_if_ctr[1];
  assign predict_target_IF = w_btb_hit ? btb_tgt_q[w_if_btb_idx] : PC_IF + 32'd4;

  assign mispredict_EX = w_upd && ((predict_br_EX != br_taken_EX) ||
                         (predict_br_EX && br_taken_EX && (pred_target_EX != br_target_EX)));
  assign correct_pc_EX = br_taken_EX ? br_target_EX : PC_EX + 32'd4;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (w_upd) begin
      br_cnt_d   = br_cnt_q + CNT_W'(1);
      miss_cnt_d = miss_cnt_q + CNT_W'(mispredict_EX);
    end
  end

  // Not-taken resolves leave the BTB alone; the BHT suppresses the prediction.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid_q[i] <= 1'b0;
      end
    end else if (w_upd && br_taken_EX) begin
      btb_valid_q[w_ex_btb_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_upd && br_taken_EX) begin
      btb_tag_q[w_ex_btb_idx] <= w_ex_tag;
      btb_tgt_q[w_ex_btb_idx] <= br_target_EX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// Module : tb_branch_predictor
// Directed vectors with a queue-based scoreboard for branch_predictor.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_predictor;

  localparam int S_PRED   = 0;
  localparam int S_BHT    = 1;
  localparam int S_TGT    = 2;
  localparam int S_MISP   = 3;
  localparam int S_CPC    = 4;
  localparam int S_BRCNT  = 5;
  localparam int S_MISCNT = 6;

  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_IF;
  logic        predict_br_IF, BHT_predict_IF;
  logic [31:0] predict_target_IF;
  logic        upd_en, br_EX, br_taken_EX;
  logic [31:0] br_target_EX, PC_EX, pred_target_EX;
  logic        predict_br_EX, BHT_predict_EX;
  logic        mispredict_EX;
  logic [31:0] correct_pc_EX;
  logic [31:0] br_cnt, miss_cnt;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  branch_predictor #(.BTB_IDX_W(6), .BHT_IDX_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .PC_IF(PC_IF),
    .predict_br_IF(predict_br_IF), .BHT_predict_IF(BHT_predict_IF),
    .predict_target_IF(predict_target_IF),
    .upd_en(upd_en), .br_EX(br_EX), .br_taken_EX(br_taken_EX),
    .br_target_EX(br_target_EX), .PC_EX(PC_EX),
    .predict_br_EX(predict_br_EX), .BHT_predict_EX(BHT_predict_EX),
    .pred_target_EX(pred_target_EX),
    .mispredict_EX(mispredict_EX), .correct_pc_EX(correct_pc_EX),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get_sig(input int s);
    case (s)
      S_PRED:   return {31'd0, predict_br_IF};
      S_BHT:    return {31'd0, BHT_predict_IF};
      S_TGT:    return predict_target_IF;
      S_MISP:   return {31'd0, mispredict_EX};
      S_CPC:    return correct_pc_EX;
      S_BRCNT:  return br_cnt;
      S_MISCNT: return miss_cnt;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: the outputs are combinational, so everything queued is checked on the next falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = get_sig(e.sig);
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic expect_sig(input int s, input logic [31:0] v, input string n);
    exp_t e;
    e.sig  = s;
    e.exp  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic expect_if(input logic p, input logic b, input logic [31:0] t, input string n);
    expect_sig(S_PRED, {31'd0, p}, {n, ".predict_br_IF"});
    expect_sig(S_BHT,  {31'd0, b}, {n, ".BHT_predict_IF"});
    expect_sig(S_TGT,  t,          {n, ".predict_target_IF"});
  endtask

  task automatic expect_cnt(input logic [31:0] br, input logic [31:0] miss, input string n);
    expect_sig(S_BRCNT,  br,   {n, ".br_cnt"});
    expect_sig(S_MISCNT, miss, {n, ".miss_cnt"});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    upd_en = 1'b0; br_EX = 1'b0; br_taken_EX = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic pbr, input logic [31:0] ptgt);
    upd_en = 1'b1; br_EX = 1'b1; br_taken_EX = taken; br_target_EX = tgt;
    PC_EX = pc; predict_br_EX = pbr; BHT_predict_EX = pbr; pred_target_EX = ptgt;
  endtask

  initial begin
    rst = 1'b1; PC_IF = 32'h100; idle_ex();
    br_target_EX = '0; PC_EX = '0; predict_br_EX = 1'b0; BHT_predict_EX = 1'b0; pred_target_EX = '0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset state and PC+4 wrap
    expect_if(1'b0, 1'b0, 32'h104, "reset");
    expect_cnt(32'd0, 32'd0, "reset");
    tick();
    PC_IF = 32'hFFFF_FFFC; PC_EX = 32'hFFFF_FFFC;
    expect_sig(S_TGT, 32'h0, "wrap.predict_target_IF");
    expect_sig(S_CPC, 32'h0, "wrap.correct_pc_EX");
    expect_sig(S_MISP, 32'd0, "idle.mispredict_EX");
    tick();

    // 2: first taken branch, unpredicted
    PC_IF = 32'h100;
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    expect_sig(S_MISP, 32'd1, "t2.mispredict_EX");
    expect_sig(S_CPC, 32'h200, "t2.correct_pc_EX");
    tick(); idle_ex();
    expect_cnt(32'd1, 32'd1, "t2");
    expect_if(1'b1, 1'b1, 32'h200, "t2");
    tick();

    // 3: saturate, then walk down with two not-takens
    for (int k = 0; k < 3; k++) begin
      resolve(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      expect_sig(S_MISP, 32'd0, "t3.taken.mispredict_EX");
      tick();
    end
    idle_ex();
    expect_cnt(32'd4, 32'd1, "t3.sat");
    tick();
    resolve(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    expect_sig(S_MISP, 32'd1, "t3.nt1.mispredict_EX");
    expect_sig(S_CPC, 32'h104, "t3.nt1.correct_pc_EX");
    tick(); idle_ex();
    expect_if(1'b1, 1'b1, 32'h200, "t3.ctr2");
    tick();
    resolve(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    tick(); idle_ex();
    expect_if(1'b0, 1'b0, 32'h200, "t3.ctr1");
    expect_cnt(32'd6, 32'd3, "t3");
    tick();

    // 4: correct direction, wrong target
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    tick();
    resolve(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    expect_sig(S_MISP, 32'd1, "t4.mispredict_EX");
    expect_sig(S_CPC, 32'h300, "t4.correct_pc_EX");
    tick(); idle_ex();
    expect_if(1'b1, 1'b1, 32'h300, "t4");
    expect_cnt(32'd8, 32'd5, "t4");
    tick();

    // non-branch never mispredicts or counts
    upd_en = 1'b1; br_EX = 1'b0; br_taken_EX = 1'b1; predict_br_EX = 1'b0;
    expect_sig(S_MISP, 32'd0, "nonbr.mispredict_EX");
    tick(); idle_ex();
    expect_cnt(32'd8, 32'd5, "nonbr");
    tick();

    // 5: alias at same BTB index, different tag
    resolve(32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
    expect_sig(S_MISP, 32'd1, "t5.mispredict_EX");
    tick(); idle_ex();
    expect_if(1'b0, 1'b1, 32'h104, "t5.alias");
    tick();
    PC_IF = 32'h200;
    expect_if(1'b1, 1'b1, 32'h400, "t5.new");
    tick();

    // 6: same-cycle update and lookup
    resolve(32'h200, 1'b1, 32'h500, 1'b1, 32'h400);
    expect_sig(S_MISP, 32'd1, "t6.mispredict_EX");
    expect_sig(S_CPC, 32'h500, "t6.correct_pc_EX");
    expect_sig(S_TGT, 32'h400, "t6.old.predict_target_IF");
    tick(); idle_ex();
    expect_sig(S_TGT, 32'h500, "t6.new.predict_target_IF");
    expect_cnt(32'd10, 32'd7, "t6");
    tick();

    // reset with a branch in EX
    rst = 1'b1;
    resolve(32'h100, 1'b1, 32'h700, 1'b0, 32'h104);
    tick();
    rst = 1'b0; idle_ex();
    expect_if(1'b0, 1'b0, 32'h204, "rst2");
    expect_cnt(32'd0, 32'd0, "rst2");
    tick();
    PC_IF = 32'h100;
    expect_if(1'b0, 1'b0, 32'h104, "rst2.pc100");
    tick();

    for (int w = 0; w < 10 && q.size() > 0; w++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: actual=%0d pending required=0 pending", q.size());
    end
    if (n_checks < 12) begin
      n_errors++;
      $display("FAIL check_count: actual=%0d required>=12", n_checks);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
